// File: rtl/rf_fifo_pkg.sv
// rf_fifo_pkg: shared sizing for the RF-backed FIFO.
// Exports data/address widths, depth, RF trim width, buffer depth.
package rf_fifo_pkg;
   localparam int RF_DW      = 24;
   localparam int RF_AW      = 8;
   localparam int RF_DEPTH   = 1 << RF_AW;
   localparam int RAM_CTRL_W = 7;
   localparam int OBUF_DEPTH = 2;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/rf_fifo_obuf.sv
// rf_fifo_obuf: 2-entry valid/ready output buffer behind the RF read port.
// Ports: clk, rst (sync, high); in_valid/in_data from RF read;
//        out_valid/out_ready/out_data to consumer; cnt = entries held.
module rf_fifo_obuf
   import rf_fifo_pkg::*;
#(
   parameter int DW = RF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    cnt
);
   logic [DW-1:0] slot0, slot1;
   logic [DW-1:0] slot0_n, slot1_n;
   logic [1:0]    cnt_q, cnt_n;
   logic          pop;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = slot0;
   assign cnt       = cnt_q;
   assign pop       = out_valid && out_ready;

   // slot0 is always the head; a pop shifts slot1 down, and an
   // incoming word lands in the first free slot after that shift.
   always_comb begin
      slot0_n = slot0;
      slot1_n = slot1;
      cnt_n   = cnt_q;
      if (pop) begin
         slot0_n = slot1;
         cnt_n   = cnt_n - 2'd1;
      end
      if (in_valid && (cnt_n != 2'd2)) begin
         if (cnt_n == 2'd0) begin
            slot0_n = in_data;
         end else begin
            slot1_n = in_data;
         end
         cnt_n = cnt_n + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_n;
      end
   end

   always_ff @(posedge clk) begin
      slot0 <= slot0_n;
      slot1 <= slot1_n;
   end
endmodule

// File: rtl/rf256x24_fifo.sv
// rf256x24_fifo: FIFO controller around an external two-port RF macro.
// Ports: clk, rst (sync, high); push_valid/push_ready/push_data;
//        pop_valid/pop_ready/pop_data; count (total held);
//        rf_we/rf_wr_addr/rf_wdata, rf_re/rf_rd_addr/rf_rdata (1-cycle read);
//        ram_ctrl_i -> ram_ctrl_o passthrough.
// Option RF_FIFO_HWM_EN adds hwm_clr input and hwm (peak count) output.
module rf256x24_fifo
   import rf_fifo_pkg::*;
#(
   parameter int DW = RF_DW,
   parameter int AW = RF_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DW-1:0]         push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DW-1:0]         pop_data,
   output logic [AW:0]           count,
   output logic                  rf_we,
   output logic [AW-1:0]         rf_wr_addr,
   output logic [DW-1:0]         rf_wdata,
   output logic                  rf_re,
   output logic [AW-1:0]         rf_rd_addr,
   input  logic [DW-1:0]         rf_rdata,
   input  logic [RAM_CTRL_W-1:0] ram_ctrl_i,
   output logic [RAM_CTRL_W-1:0] ram_ctrl_o
`ifdef RF_FIFO_HWM_EN
   ,
   input  logic                  hwm_clr,
   output logic [AW:0]           hwm
`endif
);
   localparam int DEPTH =
      (AW == RF_AW) ? RF_DEPTH : depth_of(AW);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_q, rf_cnt;
   logic          inflight;
   logic [1:0]    obuf_cnt;
   logic          obuf_valid;
   logic          push_fire, pop_fire;
   logic [2:0]    occ;

   assign push_ready = !rst && (count_q < FULL);
   assign push_fire  = push_valid && push_ready;
   assign pop_valid  = obuf_valid && !rst;
   assign pop_fire   = pop_valid && pop_ready;

   assign rf_we      = push_fire;
   assign rf_wr_addr = wr_ptr;
   assign rf_wdata   = push_data;

   // Buffer slots committed after this cycle: held words plus the
   // read already in flight, minus the word leaving now.
   assign occ = {1'b0, obuf_cnt} + {2'b00, inflight}
              - {2'b00, pop_fire};
   // rf_cnt only counts words written on earlier edges, so the
   // read address can never equal this cycle's write address.
   assign rf_re      = !rst && (rf_cnt != '0)
                    && (occ < 3'(OBUF_DEPTH));
   assign rf_rd_addr = rd_ptr;

   assign count      = count_q;
   assign ram_ctrl_o = ram_ctrl_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         rf_cnt   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= rf_re;
         if (push_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rf_re) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_fire, rf_re})
            2'b10:   rf_cnt <= rf_cnt + CNT_ONE;
            2'b01:   rf_cnt <= rf_cnt - CNT_ONE;
            default: rf_cnt <= rf_cnt;
         endcase
         case ({push_fire, pop_fire})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   rf_fifo_obuf #(
      .DW (DW)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight),
      .in_data   (rf_rdata),
      .out_valid (obuf_valid),
      .out_ready (pop_ready),
      .out_data  (pop_data),
      .cnt       (obuf_cnt)
   );

`ifdef RF_FIFO_HWM_EN
   logic [AW:0] hwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hwm_q <= '0;
      end else if (hwm_clr) begin
         hwm_q <= count_q;
      end else if (count_q > hwm_q) begin
         hwm_q <= count_q;
      end
   end

   assign hwm = hwm_q;
`endif
endmodule
